// File: rtl/aes_pkg.sv
// AES-128 shared definitions: S-box tables, GF(2^8) helpers, round constants,
// key-schedule steps and the inverse-cipher FSM state type.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYEXP,
    S_ADDKEY,
    S_ROUND,
    S_FINAL
  } aes_state_e;

  // Byte 0 sits in the most significant position so the table reads like FIPS-197.
  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[b];
  endfunction

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add GF(2^8) multiply; constant operands fold to a few XORs.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // SubWord(RotWord(w)): rotate bytes left by one, then substitute each.
  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // One forward key-schedule step: round key r-1 -> round key r.
  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // One inverse key-schedule step: round key r -> round key r-1.
  // w3 is recovered first because w0 depends on it.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rkey,
  input  logic         i_last,
  output logic [127:0] o_state
);

  logic [7:0] w_ark [16];
  logic [7:0] w_mix [16];

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // Row r rotates right by r: destination column c reads source column c-r.
      localparam int SRC = 4 * ((c - r + 4) % 4) + r;
      localparam int DST = 4 * c + r;
      assign w_ark[DST] = inv_sbox(i_state[127-8*SRC -: 8]) ^ i_rkey[127-8*DST -: 8];
    end

    assign w_mix[4*c+0] = gmul(w_ark[4*c+0], 8'h0e) ^ gmul(w_ark[4*c+1], 8'h0b) ^
                          gmul(w_ark[4*c+2], 8'h0d) ^ gmul(w_ark[4*c+3], 8'h09);
    assign w_mix[4*c+1] = gmul(w_ark[4*c+0], 8'h09) ^ gmul(w_ark[4*c+1], 8'h0e) ^
                          gmul(w_ark[4*c+2], 8'h0b) ^ gmul(w_ark[4*c+3], 8'h0d);
    assign w_mix[4*c+2] = gmul(w_ark[4*c+0], 8'h0d) ^ gmul(w_ark[4*c+1], 8'h09) ^
                          gmul(w_ark[4*c+2], 8'h0e) ^ gmul(w_ark[4*c+3], 8'h0b);
    assign w_mix[4*c+3] = gmul(w_ark[4*c+0], 8'h0b) ^ gmul(w_ark[4*c+1], 8'h0d) ^
                          gmul(w_ark[4*c+2], 8'h09) ^ gmul(w_ark[4*c+3], 8'h0e);
  end

  for (genvar i = 0; i < 16; i++) begin : g_out
    assign o_state[127-8*i -: 8] = i_last ? w_ark[i] : w_mix[i];
  end

endmodule

// File: rtl/aes128_inv_cipher.sv
// Iterative AES-128 decryption core. Expands the key forward to round key 10,
// then walks the inverse rounds one per clock, regenerating each earlier round
// key on the fly so no key table is stored.
module aes128_inv_cipher
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AES_BLK_W-1:0] key_in,
  input  logic [AES_BLK_W-1:0] data_in,
  output logic [AES_BLK_W-1:0] data_out,
  output logic                 busy,
  output logic                 done
);

  localparam logic [3:0] RC_LAST = 4'(AES_NR);

  aes_state_e           r_state, w_state_nxt;
  logic [AES_BLK_W-1:0] r_key, r_st, r_dout;
  logic [3:0]           r_rc;
  logic                 r_busy, r_done;

  logic                 w_load, w_kstep, w_addk, w_rstep, w_fin;
  logic [AES_BLK_W-1:0] w_prev_key, w_round_out;

  // Round key r-1 derived from the held round key r; rc_cnt indexes its Rcon.
  assign w_prev_key = key_inv(r_key, rcon(r_rc));

  aes_inv_round u_round (
    .i_state (r_st),
    .i_rkey  (w_prev_key),
    .i_last  (w_fin),
    .o_state (w_round_out)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and per-state datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_kstep     = 1'b0;
    w_addk      = 1'b0;
    w_rstep     = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_KEYEXP;
        end
      end
      S_KEYEXP: begin
        w_kstep = 1'b1;
        if (r_rc == RC_LAST) w_state_nxt = S_ADDKEY;
      end
      S_ADDKEY: begin
        w_addk      = 1'b1;
        w_state_nxt = S_ROUND;
      end
      S_ROUND: begin
        // rc_cnt runs 10..2 across rounds 9..1; the FINAL step uses Rcon[1].
        w_rstep = 1'b1;
        if (r_rc == 4'd2) w_state_nxt = S_FINAL;
      end
      S_FINAL: begin
        w_fin       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Key, state, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key  <= '0;
      r_st   <= '0;
      r_rc   <= '0;
      r_dout <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_load) begin
        r_key  <= key_in;
        r_st   <= data_in;
        r_rc   <= 4'd1;
        r_busy <= 1'b1;
      end
      if (w_kstep) begin
        r_key <= key_fwd(r_key, rcon(r_rc));
        // Hold at 10 so the first inverse step reuses Rcon[10].
        if (r_rc != RC_LAST) r_rc <= r_rc + 4'd1;
      end
      if (w_addk) r_st <= r_st ^ r_key;
      if (w_rstep) begin
        r_st  <= w_round_out;
        r_key <= w_prev_key;
        r_rc  <= r_rc - 4'd1;
      end
      if (w_fin) begin
        r_dout <= w_round_out;
        r_busy <= 1'b0;
      end
    end
  end

  assign data_out = r_dout;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
